// File: rtl/skinny_inv_sbox_hpc2_pipe_d2.sv
// rtl/skinny_inv_sbox_hpc2_pipe_d2.sv - 3-share masked SKINNY-64 inverse S-box, HPC2 mux gadgets on a BDD, 9-stage pipe
// BDD order: x3 (leaves) -> x2 -> x1 -> x0 (roots); 21 shared nodes, each a 2-cycle mux2_HPC2 gadget.
module skinny_inv_sbox_hpc2_pipe_d2 #(
    parameter int SECURITY_ORDER = 2,
    parameter int LATENCY        = 9,
    parameter int FRESH_W        = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         SI_s0,
    input  logic [3:0]         SI_s1,
    input  logic [3:0]         SI_s2,
    input  logic [FRESH_W-1:0] Fresh,
    output logic               out_valid,
    output logic [3:0]         SO_s0,
    output logic [3:0]         SO_s1,
    output logic [3:0]         SO_s2
);

    localparam int NG = 21;
    localparam logic [2:0] C0 = 3'b000;
    localparam logic [2:0] C1 = 3'b001;

    if (SECURITY_ORDER != 2 || LATENCY != 9 || FRESH_W != 63) begin : g_bad_param
        $error("skinny_inv_sbox_hpc2_pipe_d2: only SECURITY_ORDER=2, LATENCY=9, FRESH_W=63 supported");
    end

    logic [2:0] x3, x2, x1, x0;
    assign x3 = {SI_s2[3], SI_s1[3], SI_s0[3]};
    assign x2 = {SI_s2[2], SI_s1[2], SI_s0[2]};
    assign x1 = {SI_s2[1], SI_s1[1], SI_s0[1]};
    assign x0 = {SI_s2[0], SI_s1[0], SI_s0[0]};

    logic [2:0] g_s [NG];
    logic [2:0] g_a [NG];
    logic [2:0] g_b [NG];
    logic [2:0] g_o [NG];

    // buf_clk chains: selects and pass-through operands realigned to each gadget level
    logic [2:0] x2_q [2];
    logic [2:0] x1_q [4];
    logic [2:0] x0_q [6];
    logic [2:0] x3_node_q [2];
    logic [2:0] m2_q [2];
    logic [2:0] m3_q [2];

    always_ff @(posedge clk) begin
        x2_q[0]      <= x2;
        x2_q[1]      <= x2_q[0];
        x1_q[0]      <= x1;
        for (int i = 1; i < 4; i++) x1_q[i] <= x1_q[i-1];
        x0_q[0]      <= x0;
        for (int i = 1; i < 6; i++) x0_q[i] <= x0_q[i-1];
        x3_node_q[0] <= g_o[0];
        x3_node_q[1] <= x3_node_q[0];
        m2_q[0]      <= g_o[4];
        m2_q[1]      <= m2_q[0];
        m3_q[0]      <= g_o[5];
        m3_q[1]      <= m3_q[0];
    end

    always_comb begin
        for (int g = 0; g < 2; g++)   g_s[g] = x3;
        for (int g = 2; g < 11; g++)  g_s[g] = x2_q[1];
        for (int g = 11; g < 17; g++) g_s[g] = x1_q[3];
        for (int g = 17; g < NG; g++) g_s[g] = x0_q[5];
    end

    // Each gadget computes s ? b : a; nodes g0=x3, g1=~x3, g2..g10 over x2, g11..g16 over x1, g17..g20 = output bits 0..3
    always_comb begin
        g_a[0]  = C0;          g_b[0]  = C1;
        g_a[1]  = C1;          g_b[1]  = C0;
        g_a[2]  = C1;          g_b[2]  = C0;
        g_a[3]  = C0;          g_b[3]  = g_o[0];
        g_a[4]  = g_o[0];      g_b[4]  = C1;
        g_a[5]  = g_o[1];      g_b[5]  = C0;
        g_a[6]  = C0;          g_b[6]  = g_o[1];
        g_a[7]  = C1;          g_b[7]  = g_o[0];
        g_a[8]  = g_o[0];      g_b[8]  = g_o[1];
        g_a[9]  = C0;          g_b[9]  = C1;
        g_a[10] = g_o[1];      g_b[10] = C1;
        g_a[11] = g_o[2];      g_b[11] = g_o[4];
        g_a[12] = g_o[3];      g_b[12] = x3_node_q[1];
        g_a[13] = g_o[6];      g_b[13] = g_o[7];
        g_a[14] = g_o[5];      g_b[14] = g_o[4];
        g_a[15] = g_o[8];      g_b[15] = g_o[3];
        g_a[16] = g_o[9];      g_b[16] = g_o[10];
        g_a[17] = g_o[11];     g_b[17] = g_o[12];
        g_a[18] = m3_q[1];     g_b[18] = m2_q[1];
        g_a[19] = g_o[13];     g_b[19] = g_o[14];
        g_a[20] = g_o[15];     g_b[20] = g_o[16];
    end

    for (genvar g = 0; g < NG; g++) begin : g_gadget
        logic [2:0] d;
        logic [2:0] r;
        logic [2:0] ab_q, s_q, a_q, o_q;
        logic [5:0] nr_q, dr_q;

        assign d = g_a[g] ^ g_b[g];
        assign r = Fresh[3*g +: 3];

        // HPC2 AND of s and (a^b), r = {r12, r02, r01}; a is re-added per share at the output stage
        always_ff @(posedge clk) begin
            ab_q   <= g_s[g] & d;
            s_q    <= g_s[g];
            a_q    <= g_a[g];
            nr_q   <= {~g_s[g][2] & r[2], ~g_s[g][2] & r[1],
                       ~g_s[g][1] & r[2], ~g_s[g][1] & r[0],
                       ~g_s[g][0] & r[1], ~g_s[g][0] & r[0]};
            dr_q   <= {d[1] ^ r[2], d[0] ^ r[1],
                       d[2] ^ r[2], d[0] ^ r[0],
                       d[2] ^ r[1], d[1] ^ r[0]};
            o_q[0] <= a_q[0] ^ ab_q[0] ^ nr_q[0] ^ nr_q[1] ^ (s_q[0] & dr_q[0]) ^ (s_q[0] & dr_q[1]);
            o_q[1] <= a_q[1] ^ ab_q[1] ^ nr_q[2] ^ nr_q[3] ^ (s_q[1] & dr_q[2]) ^ (s_q[1] & dr_q[3]);
            o_q[2] <= a_q[2] ^ ab_q[2] ^ nr_q[4] ^ nr_q[5] ^ (s_q[2] & dr_q[4]) ^ (s_q[2] & dr_q[5]);
        end

        assign g_o[g] = o_q;
    end

    logic [LATENCY-1:0] vld_q;
    logic [3:0]         so0_q, so1_q, so2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            so0_q <= 4'h0;
            so1_q <= 4'h0;
            so2_q <= 4'h0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], in_valid};
            so0_q <= {g_o[20][0], g_o[19][0], g_o[18][0], g_o[17][0]};
            so1_q <= {g_o[20][1], g_o[19][1], g_o[18][1], g_o[17][1]};
            so2_q <= {g_o[20][2], g_o[19][2], g_o[18][2], g_o[17][2]};
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign SO_s0     = so0_q;
    assign SO_s1     = so1_q;
    assign SO_s2     = so2_q;

endmodule

// File: tb/tb_skinny_inv_sbox_hpc2_pipe_d2.sv
// tb/tb_skinny_inv_sbox_hpc2_pipe_d2.sv - directed bench for the masked inverse SKINNY-64 S-box pipe
module tb_skinny_inv_sbox_hpc2_pipe_d2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  SI_s0, SI_s1, SI_s2;
    logic [62:0] Fresh;
    logic        out_valid;
    logic [3:0]  SO_s0, SO_s1, SO_s2;

    int checks;
    int errors;

    logic [3:0] sinv_t [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
                                4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF};
    logic [3:0] s_t    [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    // Expected valid flag and recombined result for each sample in flight
    logic       mv [9];
    logic [3:0] me [9];

    skinny_inv_sbox_hpc2_pipe_d2 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .SI_s0    (SI_s0),
        .SI_s1    (SI_s1),
        .SI_s2    (SI_s2),
        .Fresh    (Fresh),
        .out_valid(out_valid),
        .SO_s0    (SO_s0),
        .SO_s1    (SO_s1),
        .SO_s2    (SO_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] xin, input logic [3:0] e,
                        input logic r, input logic zf);
        logic [31:0] rnd;
        logic [63:0] fr;
        rnd      = $urandom();
        fr       = {$urandom(), $urandom()};
        rst      = r;
        in_valid = v;
        SI_s0    = rnd[3:0];
        SI_s1    = rnd[7:4];
        SI_s2    = xin ^ rnd[3:0] ^ rnd[7:4];
        Fresh    = zf ? 63'd0 : fr[62:0];
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 9; i++) mv[i] = 1'b0;
        end else begin
            for (int i = 8; i > 0; i--) begin
                mv[i] = mv[i-1];
                me[i] = me[i-1];
            end
            mv[0] = v;
            me[0] = e;
        end
        @(negedge clk);
        check("out_valid", {3'b000, out_valid}, {3'b000, mv[8]});
        if (mv[8]) check("recombined", SO_s0 ^ SO_s1 ^ SO_s2, me[8]);
        if (r) begin
            check("rst_so0", SO_s0, 4'h0);
            check("rst_so1", SO_s1, 4'h0);
            check("rst_so2", SO_s2, 4'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom()), 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        SI_s0    = 4'h0;
        SI_s1    = 4'h0;
        SI_s2    = 4'h0;
        Fresh    = 63'd0;
        @(negedge clk);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h5, 4'h0, 1'b1, 1'b0);

        // Exhaustive, back-to-back, in_valid high from reset release
        for (int x = 0; x < 16; x++) step(1'b1, 4'(x), sinv_t[x], 1'b0, 1'b0);
        idle(10);

        // Valid gaps 1,0,0,1
        step(1'b1, 4'h3, 4'h8, 1'b0, 1'b0);
        step(1'b0, 4'h7, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h9, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
        idle(10);

        // Forward S then inverse returns the original nibble
        for (int x = 0; x < 16; x++) step(1'b1, s_t[x], 4'(x), 1'b0, 1'b0);
        idle(10);

        // Reset pulse with five samples in flight discards them all
        for (int x = 0; x < 5; x++) step(1'b1, 4'(x + 1), sinv_t[x + 1], 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(12);

        // Mask and Fresh independence, including Fresh=0
        for (int i = 0; i < 100; i++) step(1'b1, 4'hB, 4'h7, 1'b0, (i % 4) == 0);
        for (int x = 0; x < 16; x++) step(1'b1, 4'(x), sinv_t[x], 1'b0, 1'b1);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
